jt12_timer_ab: RTL and testbench
================================

Name: jt12_timer_ab

Overview:
- Timer A / Timer B block of the OPN core; sits directly downstream of the clock-enable divider and consumes its `clk_en` pulse train.
- Counts enable pulses into the two chip timers and raises the status flags and the active-low IRQ.
- Emits a one-cycle Timer A overflow strobe for CSM key-on logic.
- Register decoding is upstream; this block receives already-latched register fields.

Parameters:
- PRES_A, 24, `clk_en` pulses per Timer A tick (144 master clocks / divide-by-6).
- PRES_B, 16, Timer A ticks per Timer B tick.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- clk_en  input  1  single-cycle enable from the clock divider
- value_a  input  10  Timer A reload value (reg 0x24/0x25)
- value_b  input  8  Timer B reload value (reg 0x26)
- load_a  input  1  Timer A run/load bit (reg 0x27 bit0)
- load_b  input  1  Timer B run/load bit (reg 0x27 bit1)
- en_flag_a  input  1  Timer A flag enable (bit2)
- en_flag_b  input  1  Timer B flag enable (bit3)
- clr_flag_a  input  1  one-cycle flag A reset strobe (bit4 write)
- clr_flag_b  input  1  one-cycle flag B reset strobe (bit5 write)
- flag_a  output  1  Timer A status flag
- flag_b  output  1  Timer B status flag
- overflow_a  output  1  one-cycle strobe on Timer A overflow
- irq_n  output  1  active-low interrupt, equal to ~(flag_a | flag_b)

Behaviour:
- Reset (rst_n low, async):
  - All counters and prescalers go to 0.
  - flag_a=0, flag_b=0, overflow_a=0, irq_n=1.
  - Previous-load registers go to 0.
- Prescaler A:
  - Counts `clk_en` pulses 0..PRES_A-1.
  - Asserts tick_a in the cycle where it wraps (a `clk_en` pulse arrives with count = PRES_A-1).
  - Free-running; independent of load_a.
- Prescaler B:
  - 4-bit counter; advances on each tick_a.
  - Asserts tick_b in the cycle where it wraps (count = PRES_B-1 on a tick_a).
- Timer A counter (10-bit):
  - Rising edge of load_a (registered previous value 0, current value 1) loads value_a into the counter in that clk.
  - While load_a=1, the counter increments on each tick_a.
  - A tick_a with counter=1023 is an overflow: the counter reloads value_a, not 0.
  - Period = (1024 - value_a) ticks. value_a=1023 overflows every tick.
  - While load_a=0, the counter holds; no overflow occurs.
  - A load edge coinciding with tick_a: the load takes priority and the tick is dropped.
- Timer B counter (8-bit): same rules using value_b, tick_b, load_b, wrap at 255.
- value_a / value_b changes while running affect only the next load edge or reload.
- overflow_a:
  - Registered; high for exactly one clk in the cycle after the Timer A overflow.
  - Asserted regardless of en_flag_a.
- Flags:
  - flag_x is set in the cycle after a Timer x overflow, if en_flag_x=1 at the overflow.
  - flag_x clears in the cycle after clr_flag_x.
  - Set and clear in the same cycle: set wins.
  - Clearing en_flag_x does not clear an already-set flag.
- irq_n is registered from the next-state flags, so it changes in the same cycle as the flags.
- No combinational path from any input to any output.

Decomposition:
- Shared package/header: PRES_A, PRES_B defaults and timer width constants (TA_W=10, TB_W=8).
- One natural sub-module: jt12_timer_cnt.
  - Parameterised width; handles load-edge detect, count, reload on overflow, flag set/clear and overflow strobe.
  - Instantiated twice: for Timer A with tick_a; for Timer B with tick_b.
- The top level holds the two prescalers and the irq_n register.

Test Plan:
- Reset release, `clk_en` every 6 clks, load_a=0 -> flags 0, irq_n=1, overflow_a never pulses over 10000 clks.
- value_a=1022, load_a 0->1, en_flag_a=1 -> first overflow after 2 ticks_a (48 `clk_en` pulses); flag_a=1 and irq_n=0 in the same clk; overflow_a repeats every 48 `clk_en` pulses.
- value_b=254, load_b=1, en_flag_b=0 -> flag_b stays 0, irq_n=1. Set en_flag_b=1 -> flag_b=1 at the next overflow; Timer B period = 2*16*24 = 768 `clk_en` pulses.
- Flag set and clr_flag_a in the same cycle -> flag_a stays 1. clr_flag_a on the next cycle -> flag_a=0, irq_n=1 one clk later.
- Change value_a from 1022 to 1000 mid-run -> the current period is unchanged and the next period is 24 ticks. Drop load_a -> the counter freezes. Re-raise load_a -> reload to 1000.
- Assert rst_n=0 mid-count with flags set -> all outputs return to reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/jt12_timer_ab_pkg.sv
// Shared constants for the OPN Timer A / Timer B block.
package jt12_timer_ab_pkg;

  // clk_en pulses per Timer A tick (144 master clocks after the divide-by-6)
  localparam int PRES_A_DEF = 24;
  // Timer A ticks per Timer B tick
  localparam int PRES_B_DEF = 16;

  localparam int TA_W = 10;
  localparam int TB_W = 8;

  // Width of a 0..n-1 prescaler; keeps at least one bit for degenerate n
  function automatic int pres_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/jt12_timer_cnt.sv
// One chip timer: load-edge detect, up-count on tick, reload on overflow,
// status flag with set-over-clear priority and a one-cycle overflow strobe.
module jt12_timer_cnt #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick_i,
  input  logic [W-1:0] value_i,
  input  logic         load_i,
  input  logic         en_flag_i,
  input  logic         clr_flag_i,
  output logic         flag_o,
  output logic         flag_d_o,
  output logic         overflow_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         load_prev_q;
  logic         flag_q, flag_d;
  logic         ovf_q, ovf_d;

  // Next-state: a load edge wins over a coincident tick, which is dropped
  always_comb begin
    cnt_d  = cnt_q;
    ovf_d  = 1'b0;
    flag_d = flag_q;
    if (load_i && !load_prev_q) begin
      cnt_d = value_i;
    end else if (load_i && tick_i) begin
      if (cnt_q == {W{1'b1}}) begin
        cnt_d = value_i;
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
    if (ovf_d && en_flag_i) begin
      flag_d = 1'b1;
    end else if (clr_flag_i) begin
      flag_d = 1'b0;
    end
  end

  // State registers; overflow strobe and flag both land one cycle after the wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      load_prev_q <= 1'b0;
      flag_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      load_prev_q <= load_i;
      flag_q      <= flag_d;
      ovf_q       <= ovf_d;
    end
  end

  assign flag_o     = flag_q;
  assign flag_d_o   = flag_d;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/jt12_timer_ab.sv
// Timer A / Timer B of the OPN core: prescalers from clk_en, two timer
// instances and the registered active-low interrupt.
module jt12_timer_ab
  import jt12_timer_ab_pkg::*;
#(
  parameter int PRES_A = PRES_A_DEF,
  parameter int PRES_B = PRES_B_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clk_en,
  input  logic [TA_W-1:0] value_a,
  input  logic [TB_W-1:0] value_b,
  input  logic            load_a,
  input  logic            load_b,
  input  logic            en_flag_a,
  input  logic            en_flag_b,
  input  logic            clr_flag_a,
  input  logic            clr_flag_b,
  output logic            flag_a,
  output logic            flag_b,
  output logic            overflow_a,
  output logic            irq_n
);

  localparam int PA_W = pres_width(PRES_A);
  localparam int PB_W = pres_width(PRES_B);

  logic [PA_W-1:0] pres_a_q, pres_a_d;
  logic [PB_W-1:0] pres_b_q, pres_b_d;
  logic            tick_a, tick_b;
  logic            flag_a_d, flag_b_d;
  logic            irq_n_q;
  logic            unused_ovf_b;

  // Prescaler chain: A free-runs on clk_en, B advances on each tick_a
  always_comb begin
    pres_a_d = pres_a_q;
    pres_b_d = pres_b_q;
    tick_a   = 1'b0;
    tick_b   = 1'b0;
    if (clk_en) begin
      if (pres_a_q == PA_W'(PRES_A - 1)) begin
        pres_a_d = '0;
        tick_a   = 1'b1;
      end else begin
        pres_a_d = pres_a_q + PA_W'(1);
      end
    end
    if (tick_a) begin
      if (pres_b_q == PB_W'(PRES_B - 1)) begin
        pres_b_d = '0;
        tick_b   = 1'b1;
      end else begin
        pres_b_d = pres_b_q + PB_W'(1);
      end
    end
  end

  // Prescaler registers and irq_n taken from next-state flags so it moves with them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pres_a_q <= '0;
      pres_b_q <= '0;
      irq_n_q  <= 1'b1;
    end else begin
      pres_a_q <= pres_a_d;
      pres_b_q <= pres_b_d;
      irq_n_q  <= ~(flag_a_d | flag_b_d);
    end
  end

  jt12_timer_cnt #(.W(TA_W)) u_timer_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_i     (tick_a),
    .value_i    (value_a),
    .load_i     (load_a),
    .en_flag_i  (en_flag_a),
    .clr_flag_i (clr_flag_a),
    .flag_o     (flag_a),
    .flag_d_o   (flag_a_d),
    .overflow_o (overflow_a)
  );

  // Timer B has no CSM role, so its overflow strobe goes nowhere
  jt12_timer_cnt #(.W(TB_W)) u_timer_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_i     (tick_b),
    .value_i    (value_b),
    .load_i     (load_b),
    .en_flag_i  (en_flag_b),
    .clr_flag_i (clr_flag_b),
    .flag_o     (flag_b),
    .flag_d_o   (flag_b_d),
    .overflow_o (unused_ovf_b)
  );

  assign irq_n = irq_n_q;

endmodule

// File: tb/tb_jt12_timer_ab.sv
// Self-checking bench for jt12_timer_ab: a cycle-level reference model pushes
// the expected outputs of every clock into a scoreboard queue, popped and
// compared half a cycle after the edge, plus directed period/flag checks.
module tb_jt12_timer_ab;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clk_en;
  logic [9:0] value_a;
  logic [7:0] value_b;
  logic       load_a, load_b;
  logic       en_flag_a, en_flag_b;
  logic       clr_flag_a, clr_flag_b;
  logic       flag_a, flag_b, overflow_a, irq_n;

  always #5 clk = ~clk;

  jt12_timer_ab dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_en     (clk_en),
    .value_a    (value_a),
    .value_b    (value_b),
    .load_a     (load_a),
    .load_b     (load_b),
    .en_flag_a  (en_flag_a),
    .en_flag_b  (en_flag_b),
    .clr_flag_a (clr_flag_a),
    .clr_flag_b (clr_flag_b),
    .flag_a     (flag_a),
    .flag_b     (flag_b),
    .overflow_a (overflow_a),
    .irq_n      (irq_n)
  );

  typedef struct packed {
    logic fa;
    logic fb;
    logic ova;
    logic irqn;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: timers tracked as ticks remaining until overflow
  int m_pa, m_pb, m_rem_a, m_rem_b, div;
  bit m_prev_a, m_prev_b, m_fa, m_fb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pa = 0; m_pb = 0; m_rem_a = 0; m_rem_b = 0;
    m_prev_a = 0; m_prev_b = 0; m_fa = 0; m_fb = 0;
  endtask

  // One clock: drive clk_en, predict, push, clock, pop and compare
  task automatic cycle();
    exp_t e;
    bit ta, tb, oa, ob;
    clk_en = (div == 0);
    div = (div == 5) ? 0 : div + 1;
    ta = clk_en && (m_pa == 23);
    if (clk_en) m_pa = (m_pa == 23) ? 0 : m_pa + 1;
    tb = ta && (m_pb == 15);
    if (ta) m_pb = (m_pb == 15) ? 0 : m_pb + 1;
    oa = 0;
    if (load_a && !m_prev_a) m_rem_a = 1024 - int'(value_a);
    else if (load_a && ta) begin
      m_rem_a--;
      if (m_rem_a == 0) begin oa = 1; m_rem_a = 1024 - int'(value_a); end
    end
    m_prev_a = load_a;
    ob = 0;
    if (load_b && !m_prev_b) m_rem_b = 256 - int'(value_b);
    else if (load_b && tb) begin
      m_rem_b--;
      if (m_rem_b == 0) begin ob = 1; m_rem_b = 256 - int'(value_b); end
    end
    m_prev_b = load_b;
    if (oa && en_flag_a) m_fa = 1; else if (clr_flag_a) m_fa = 0;
    if (ob && en_flag_b) m_fb = 1; else if (clr_flag_b) m_fb = 0;
    e = '{fa: m_fa, fb: m_fb, ova: oa, irqn: !(m_fa || m_fb)};
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    check("outs{fa,fb,ova,irqn}", {28'd0, flag_a, flag_b, overflow_a, irq_n}, {28'd0, e});
  endtask

  task automatic wait_ovf_a(input int max, output int n);
    n = 0;
    do begin cycle(); n++; end while (!overflow_a && n < max);
    check("ovfa_seen", {31'd0, overflow_a}, 32'd1);
  endtask

  task automatic wait_flag_b(input int max, output int n);
    n = 0;
    do begin cycle(); n++; end while (!flag_b && n < max);
    check("flagb_seen", {31'd0, flag_b}, 32'd1);
  endtask

  initial begin
    int n, n2, pulses, guard;
    rst_n = 0; clk_en = 0; value_a = 0; value_b = 0;
    load_a = 0; load_b = 0; en_flag_a = 0; en_flag_b = 0;
    clr_flag_a = 0; clr_flag_b = 0;
    div = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_flag_a", {31'd0, flag_a}, 32'd0);
    check("rst_flag_b", {31'd0, flag_b}, 32'd0);
    check("rst_ovf_a", {31'd0, overflow_a}, 32'd0);
    check("rst_irq_n", {31'd0, irq_n}, 32'd1);
    rst_n = 1;

    // Timers idle: nothing may fire
    pulses = 0;
    for (int i = 0; i < 10000; i++) begin
      cycle();
      if (overflow_a) pulses++;
    end
    check("idle_ovf_count", pulses, 0);

    // Timer B with flag disabled, then enabled: period 768 clk_en = 4608 clks
    value_b = 8'd254; load_b = 1;
    for (int i = 0; i < 10000; i++) cycle();
    check("b_noflag", {31'd0, flag_b}, 32'd0);
    check("b_noflag_irq", {31'd0, irq_n}, 32'd1);
    en_flag_b = 1;
    wait_flag_b(5000, n);
    clr_flag_b = 1; cycle(); clr_flag_b = 0;
    check("b_clr", {31'd0, flag_b}, 32'd0);
    wait_flag_b(5000, n2);
    check("b_period", n2 + 1, 4608);
    en_flag_b = 0;
    clr_flag_b = 1; cycle(); clr_flag_b = 0;

    // Timer A at 1022: two ticks per period = 48 clk_en = 288 clks
    value_a = 10'd1022; en_flag_a = 1; load_a = 1;
    wait_ovf_a(400, n);
    check("a_first_flag", {31'd0, flag_a}, 32'd1);
    check("a_first_irq", {31'd0, irq_n}, 32'd0);
    wait_ovf_a(400, n);
    check("a_period1", n, 288);
    wait_ovf_a(400, n);
    check("a_period2", n, 288);

    // Clear racing a set: set wins, clear on the following cycle sticks
    guard = 0;
    while (!((div == 0) && (m_pa == 23) && load_a && m_prev_a && (m_rem_a == 1)) && guard < 400) begin
      cycle(); guard++;
    end
    clr_flag_a = 1; cycle();
    check("set_wins", {31'd0, flag_a}, 32'd1);
    check("set_wins_ovf", {31'd0, overflow_a}, 32'd1);
    cycle(); clr_flag_a = 0;
    check("clr_a", {31'd0, flag_a}, 32'd0);
    check("clr_a_irq", {31'd0, irq_n}, 32'd1);

    // Reload value change mid-run only affects the next reload
    wait_ovf_a(400, n);
    value_a = 10'd1000;
    wait_ovf_a(400, n);
    check("a_old_period", n, 288);
    wait_ovf_a(4000, n);
    check("a_new_period", n, 3456);

    // Freeze with load_a low, then re-raise to reload 1000
    load_a = 0;
    pulses = 0;
    for (int i = 0; i < 4000; i++) begin
      cycle();
      if (overflow_a) pulses++;
    end
    check("frozen_ovf_count", pulses, 0);
    load_a = 1;
    wait_ovf_a(4000, n);
    wait_ovf_a(4000, n);
    check("a_reload_period", n, 3456);

    // Asynchronous reset with a flag set, between clock edges
    en_flag_b = 1;
    for (int i = 0; i < 100; i++) cycle();
    check("pre_rst_flags", {31'd0, flag_a | flag_b}, 32'd1);
    #2 rst_n = 0;
    #1;
    check("arst_flag_a", {31'd0, flag_a}, 32'd0);
    check("arst_flag_b", {31'd0, flag_b}, 32'd0);
    check("arst_ovf_a", {31'd0, overflow_a}, 32'd0);
    check("arst_irq_n", {31'd0, irq_n}, 32'd1);
    @(negedge clk);
    load_a = 0; load_b = 0;
    model_reset();
    rst_n = 1;
    for (int i = 0; i < 300; i++) cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
